// File: rtl/ipml_prefetch_fifo_v2_0_sync.sv
// Single-clock FWFT prefetch FIFO: simple-dual-port RAM with 1-cycle read feeding a
// 2-entry output buffer, so both ports sustain one word per cycle.
module ipml_prefetch_fifo_v2_0_sync #(
  parameter int DEPTH_WIDTH  = 10,
  parameter int DATA_WIDTH   = 24,
  parameter int AFULL_LEVEL  = 1000,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_en,
  output logic                   wr_vld,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_en,
  output logic                   rd_vld,
  output logic [DEPTH_WIDTH+1:0] water_level,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int RAM_DEPTH = 1 << DEPTH_WIDTH;
  localparam int LW        = DEPTH_WIDTH + 2;
  localparam logic [DEPTH_WIDTH:0] RAM_FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [LW-1:0] AF_LVL = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] AE_LVL = LW'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0]       mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]       ram_q;
  logic [DEPTH_WIDTH-1:0]      wr_ptr, rd_ptr;
  logic [DEPTH_WIDTH:0]        ram_count;
  logic                        inflight;
  logic [1:0]                  ob_count;
  logic [1:0][DATA_WIDTH-1:0]  ob;
  logic                        wr_fire, pop, issue;
  logic [1:0]                  occ_left, ob_left;

  assign wr_vld  = (ram_count != RAM_FULL);
  assign rd_vld  = (ob_count != 2'd0);
  assign rd_data = ob[0];

  assign wr_fire = wr_en & wr_vld & ~flush;
  assign pop     = rd_en & rd_vld & ~flush;

  // ob_count + inflight never exceeds 2, so the sum fits two bits.
  assign occ_left = ob_count + {1'b0, inflight} - {1'b0, pop};
  assign ob_left  = ob_count - {1'b0, pop};
  assign issue    = (ram_count != '0) && (occ_left < 2'd2) && !flush;

  assign water_level  = {1'b0, ram_count} + {{(LW-1){1'b0}}, inflight} + {{(LW-2){1'b0}}, ob_count};
  assign almost_full  = (water_level >= AF_LVL);
  assign almost_empty = (water_level <= AE_LVL);

  // Read only ever targets words written on an earlier edge, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
    if (issue)   ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      inflight  <= 1'b0;
      ob_count  <= 2'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      inflight  <= 1'b0;
      ob_count  <= 2'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
      if (issue)   rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
      if (wr_fire && !issue)      ram_count <= ram_count + (DEPTH_WIDTH+1)'(1);
      else if (!wr_fire && issue) ram_count <= ram_count - (DEPTH_WIDTH+1)'(1);
      inflight <= issue;
      ob_count <= occ_left;
      if (wr_en && !wr_vld) overflow  <= 1'b1;
      if (rd_en && !rd_vld) underflow <= 1'b1;
    end
  end

  // Landing word goes behind whatever survives this cycle's pop; it overrides the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob <= '0;
    end else begin
      if (pop)      ob[0] <= ob[1];
      if (inflight) ob[ob_left[0]] <= ram_q;
    end
  end

endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0_sync.sv
// Bench for the prefetch FIFO: directed and random steps checked against a word-queue model.
module tb_ipml_prefetch_fifo_v2_0_sync;
  localparam int DW  = 4;
  localparam int DAW = 8;
  localparam int AF  = 16;
  localparam int AE  = 2;
  localparam int CAP = (1 << DW) + 2;

  logic clk = 1'b0;
  logic rst, flush, wr_en, rd_en;
  logic [DAW-1:0] wr_data, rd_data;
  logic wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
  logic [DW+1:0] water_level;

  ipml_prefetch_fifo_v2_0_sync #(
    .DEPTH_WIDTH(DW), .DATA_WIDTH(DAW), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_data(wr_data), .wr_en(wr_en), .wr_vld(wr_vld),
    .rd_data(rd_data), .rd_en(rd_en), .rd_vld(rd_vld),
    .water_level(water_level), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // A word is visible at the head two edges after it was accepted; occupancy is the queue size.
  typedef struct { logic [DAW-1:0] d; int t; } word_t;
  word_t q[$];
  int ecnt = 0;
  bit m_ovf = 0, m_unf = 0;
  int checks = 0, errors = 0;

  function automatic bit m_rd_vld();
    return (q.size() > 0) && (q[0].t + 2 <= ecnt);
  endfunction

  function automatic bit m_wr_vld();
    return q.size() < CAP;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("wr_vld", wr_vld, m_wr_vld());
    chk("rd_vld", rd_vld, m_rd_vld());
    chk("water_level", water_level, q.size());
    chk("almost_full", almost_full, q.size() >= AF);
    chk("almost_empty", almost_empty, q.size() <= AE);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    if (m_rd_vld()) chk("rd_data", rd_data, q[0].d);
  endtask

  task automatic check_reset_vals();
    chk("rst_wr_vld", wr_vld, 1);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_level", water_level, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
  endtask

  // One clock: check state, drive inputs, advance model across the edge.
  task automatic cyc(input bit we, input logic [DAW-1:0] d, input bit re, input bit fl);
    bit wv, rv;
    word_t w;
    check_all();
    wr_en = we; wr_data = d; rd_en = re; flush = fl;
    wv = m_wr_vld();
    rv = m_rd_vld();
    @(posedge clk);
    ecnt++;
    if (fl) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (re && rv) void'(q.pop_front());
      if (we && wv) begin
        w.d = d; w.t = ecnt;
        q.push_back(w);
      end
      if (we && !wv) m_ovf = 1;
      if (re && !rv) m_unf = 1;
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #12;
    check_reset_vals();
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // single word with rd_en held: 2-edge latency, then pop
    cyc(1, 8'h01, 1, 0);
    repeat (4) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);

    // fill to capacity, overflow attempt, then drain in order
    for (int i = 0; i < CAP + 1; i++) cyc(1, DAW'(i), 0, 0);
    chk("full_level", water_level, CAP);
    chk("full_wr_vld", wr_vld, 0);
    for (int i = 0; i < CAP; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 1);

    // streaming 100 words, both ports every cycle
    for (int i = 0; i < 100; i++) cyc(1, DAW'(i * 7 + 3), 1, 0);
    repeat (5) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);

    // underflow on empty, cleared by flush
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    chk("unf_set", underflow, 1);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0);

    // flush with concurrent write/read, then a fresh word
    for (int i = 0; i < 10; i++) cyc(1, DAW'(8'h40 + i), 0, 0);
    cyc(1, 8'hFF, 1, 1);
    cyc(1, 8'hAB, 0, 0);
    repeat (3) cyc(0, 8'h00, 0, 0);
    chk("flush_head", rd_data, 8'hAB);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 8; i++) cyc(1, DAW'(8'h60 + i), (i > 4), 0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    #2 rst = 1'b1;
    #1;
    check_reset_vals();
    wr_en = 1'b0; rd_en = 1'b0;
    q.delete(); m_ovf = 0; m_unf = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cyc(1, 8'h5A, 0, 0);
    repeat (3) cyc(0, 8'h00, 0, 0);
    chk("post_rst_head", rd_data, 8'h5A);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);

    // random traffic: write-heavy phase then balanced, rare flushes
    for (int i = 0; i < 600; i++) begin
      bit we, re, fl;
      if (i < 250) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else begin
        we = $urandom_range(0, 1) == 1;
        re = $urandom_range(0, 1) == 1;
      end
      fl = ($urandom_range(0, 79) == 0);
      cyc(we, DAW'($urandom_range(0, 255)), re, fl);
    end
    cyc(0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
